prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter WRAP_OK, default 1: 1 permits address wrap 8'hFF->8'h00 during a load; 0 rejects any load whose base_addr+length exceeds 256.
REQ-002 Parameter CHK_INIT, default 8'h00: initial checksum value loaded on each accepted start.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
REQ-006 base_addr  input  8  first instruction-memory byte address; sampled with start.
REQ-007 length  input  8  byte count; sampled with start; 0 means no bytes.
REQ-008 abort  input  1  terminates an active load.
REQ-009 in_valid  input  1  source presents a program byte.
REQ-010 in_data  input  8  program byte.
REQ-011 in_ready  output  1  loader accepts a byte this cycle.
REQ-012 mem_we  output  1  instruction-memory byte write strobe.
REQ-013 mem_waddr  output  8  write address.
REQ-014 mem_din  output  8  write data.
REQ-015 busy  output  1  load in progress; also serves as the CPU fetch hold.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 err  output  1  level; high while in ERR.
REQ-018 checksum  output  8  running sum of accepted bytes, mod 256.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, DONE, ERR.
REQ-020 IDLE/DONE/ERR with start=1: odd length -> ERR; WRAP_OK=0 and base_addr+length>256 (9-bit sum) -> ERR; length=0 -> DONE; otherwise -> LOAD with addr=base_addr, remaining=length, checksum=CHK_INIT.
REQ-021 Checksum SHALL be reset to CHK_INIT only on a start that enters LOAD or DONE; a rejected start leaves it unchanged.
REQ-022 DONE SHALL last exactly one cycle with done=1, then go to IDLE unless start=1 in that cycle.
REQ-023 ERR SHALL persist until start or rst.
REQ-024 in_ready SHALL be 1 exactly when state=LOAD and remaining!=0.
REQ-025 A beat is accepted when in_valid and in_ready are both 1; in_valid SHALL be honoured with no combinational dependence of in_ready on in_valid.
REQ-026 Each accepted beat SHALL produce mem_we=1 for exactly the next cycle, with mem_waddr = current addr and mem_din = in_data (registered, 1-cycle latency).
REQ-027 Each accepted beat SHALL increment addr mod 256, decrement remaining, and add in_data to checksum mod 256.
REQ-028 The last accepted beat (remaining 1->0) SHALL move LOAD->DONE; its mem_we and done SHALL assert in the same cycle.
REQ-029 Idle cycles (in_valid=0) in LOAD SHALL produce no write and no state change.
REQ-030 abort=1 in LOAD SHALL go to ERR next cycle and discard any beat presented that cycle (no write, no checksum update); abort is ignored outside LOAD.
REQ-031 start in LOAD SHALL be ignored.
REQ-032 busy SHALL be 1 in LOAD and 0 elsewhere.
REQ-033 mem_we SHALL never assert outside the cycle following an accepted beat.

Reset
REQ-034 rst=0 SHALL immediately force IDLE, in_ready=0, mem_we=0, mem_waddr=0, mem_din=0, busy=0, done=0, err=0, checksum=CHK_INIT, and clear addr and remaining.
REQ-035 Reset mid-load SHALL abandon the load with no further writes; the first start after reset release SHALL behave as a fresh load.

Verification
REQ-036 start, base=8'h10, length=4, bytes 01,02,03,04 back-to-back -> writes at 10..13, checksum 8'h0A, done pulse in the cycle of the write to 13, then IDLE.
REQ-037 WRAP_OK=1, base=8'hFE, length=4 -> writes at FE,FF,00,01; WRAP_OK=0 with same stimulus -> ERR, zero writes, err=1.
REQ-038 length=3 -> ERR, no writes, checksum unchanged; length=0 -> one-cycle done, no writes, busy stays 0.
REQ-039 length=6 with in_valid toggling 1,0,1,0 -> exactly 6 writes to consecutive addresses, none in gap cycles.
REQ-040 abort after 2 of 6 beats, concurrent with a valid beat -> exactly 2 writes, ERR, checksum covers 2 bytes; subsequent start recovers to LOAD.
REQ-041 rst=0 asserted mid-load between clock edges -> outputs reach reset values before the next edge; no write after release until a new start.

Source files
------------

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Streams program bytes into instruction memory with a checksum.
// Revision : 1.0
// ============================================================================
module prog_loader #(
  parameter int       WRAP_OK  = 1,
  parameter bit [7:0] CHK_INIT = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] base_addr_i,
  input  logic [7:0] length_i,
  input  logic       abort_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       mem_we_o,
  output logic [7:0] mem_waddr_o,
  output logic [7:0] mem_din_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] checksum_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] chk_q, chk_d;
  logic       we_q, we_d;
  logic [7:0] waddr_q, waddr_d;
  logic [7:0] din_q, din_d;

  logic       w_accept;
  logic [8:0] w_end;
  logic       w_overflow;
  logic       w_ready;

  // Ready depends on state and count only, never on in_valid.
  assign w_ready    = (state_q == LOAD) && (rem_q != 8'd0);
  assign w_accept   = w_ready && in_valid_i && !abort_i;
  assign w_end      = {1'b0, base_addr_i} + {1'b0, length_i};
  assign w_overflow = (WRAP_OK == 0) && (w_end > 9'd256);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    chk_d   = chk_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    din_d   = din_q;
    case (state_q)
      LOAD: begin
        if (abort_i) begin
          state_d = ERR;
        end else if (w_accept) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          din_d   = in_data_i;
          addr_d  = addr_q + 8'd1;
          rem_d   = rem_q - 8'd1;
          chk_d   = chk_q + in_data_i;
          if (rem_q == 8'd1) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        // IDLE, DONE and ERR all accept a new request; a rejected one
        // leaves the checksum of the previous load visible.
        if (start_i) begin
          if (length_i[0] || w_overflow) begin
            state_d = ERR;
          end else if (length_i == 8'd0) begin
            state_d = DONE;
            chk_d   = CHK_INIT;
            rem_d   = 8'd0;
            addr_d  = base_addr_i;
          end else begin
            state_d = LOAD;
            addr_d  = base_addr_i;
            rem_d   = length_i;
            chk_d   = CHK_INIT;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= 8'd0;
      rem_q   <= 8'd0;
      chk_q   <= CHK_INIT;
      we_q    <= 1'b0;
      waddr_q <= 8'd0;
      din_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      chk_q   <= chk_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
    end
  end

  assign in_ready_o  = w_ready;
  assign mem_we_o    = we_q;
  assign mem_waddr_o = waddr_q;
  assign mem_din_o   = din_q;
  assign busy_o      = (state_q == LOAD);
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == ERR);
  assign checksum_o  = chk_q;

endmodule
`default_nettype wire
